uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the requester-side and transmitter-side signals of the UART TX
// arbiter. The clock and reset stay as plain ports on the arbiter.
//
// Signals:
//   req[3:0]        per-requester byte-send request (level)
//   req_data[31:0]  byte for requester i on bits [8i+7:8i]
//   gnt[3:0]        one-hot, one-cycle grant pulse (data captured)
//   done[3:0]       one-hot, one-cycle pulse when requester's byte is sent
//   tx_enable       start strobe to the transmitter (level)
//   TX_BYTE[7:0]    byte presented to the transmitter
//   TX_BUSSY        transmitter busy
//   TX_VALID        transmitter completion pulse
//   arb_busy        high whenever the arbiter is not idle
//   owner[1:0]      index of current/last granted requester
//   timeout_err     one-cycle pulse when a byte is aborted by the timeout
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tx_enable;
    logic [7:0]  TX_BYTE;
    logic        TX_BUSSY;
    logic        TX_VALID;
    logic        arb_busy;
    logic [1:0]  owner;
    logic        timeout_err;

    modport slave (
        input  req, req_data, TX_BUSSY, TX_VALID,
        output gnt, done, tx_enable, TX_BYTE, arb_busy, owner, timeout_err
    );

    modport master (
        output req, req_data, TX_BUSSY, TX_VALID,
        input  gnt, done, tx_enable, TX_BYTE, arb_busy, owner, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among four requesters.
// In IDLE a pending request is granted (search order last+1 .. last), its
// byte is captured onto TX_BYTE, and the FSM walks START -> SEND -> IDLE
// following the transmitter's TX_BUSSY / TX_VALID handshake.
//
// Ports:
//   clk  - system clock, all logic on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - uart_tx_arbiter_if.slave (req, req_data, gnt, done, tx_enable,
//          TX_BYTE, TX_BUSSY, TX_VALID, arb_busy, owner, timeout_err)
//
// Parameters:
//   TIMEOUT_CYCLES - cycle limit per byte in START+SEND (timeout build only)
//
// Build option:
//   UART_ARB_TIMEOUT_EN - when defined, a per-byte cycle counter aborts a
//   stalled byte after TIMEOUT_CYCLES cycles and pulses timeout_err. When
//   undefined there is no counter, timeout_err is tied low and the FSM
//   waits indefinitely for the transmitter.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    // The timeout needs at least one START cycle before the abort point.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] done_q, done_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [1:0] winner;
    logic       timeout_hit;

    // Round-robin pick: scan from farthest (last+4 == last) down to nearest
    // (last+1) so the nearest pending requester after 'last' overwrites
    // the others and wins.
    always_comb begin
        winner = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[last_q + 2'(k)]) begin
                winner = last_q + 2'(k);
            end
        end
    end

    // Main FSM. gnt and done are one-cycle pulses, so they default to zero
    // and are only set on the edge that starts or finishes a byte. A
    // completion in SEND takes priority over a timeout in the same cycle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = '0;
        tx_byte_d = tx_byte_q;
        owner_d   = owner_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d[winner] = 1'b1;
                    tx_byte_d     = bus.req_data[{winner, 3'b000} +: 8];
                    owner_d       = winner;
                    last_d        = winner;
                    state_d       = ST_START;
                end
            end
            ST_START: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (bus.TX_BUSSY) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.TX_VALID) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset leaves last at 3 so requester 0
    // is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            tx_byte_q <= 8'h00;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            tx_byte_q <= tx_byte_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // The counter sits at zero in IDLE, so it is already clear on the
    // grant edge and counts every START/SEND cycle of the byte.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q != ST_IDLE) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign timeout_hit   = (state_q != ST_IDLE) && (tmo_cnt_q == CNT_LAST);
    assign timeout_err_d = timeout_hit && !((state_q == ST_SEND) && bus.TX_VALID);

    // Timeout counter and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.TX_BYTE   = tx_byte_q;
    assign bus.owner     = owner_q;
    assign bus.tx_enable = (state_q == ST_START);
    assign bus.arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. A transaction-level model keeps
// the round-robin pointer and predicts the winner, captured byte and the
// gnt/done pulses; the transmitter handshake is driven directly from the
// stimulus sequence. Timeout checks are compiled only when
// UART_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 16).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   modelLast;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Next requester after 'last' in circular order that is requesting.
    function automatic int pickWinner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oneHot(input int idx);
        return 4'b0001 << idx;
    endfunction

    // One complete byte: grant from IDLE, startDelay START cycles (with a
    // stray TX_VALID sometimes), TX_BUSSY, busyCycles SEND cycles, TX_VALID.
    // busyReq is the req pattern shown while the arbiter is busy.
    task automatic applyStimulus(input logic [3:0] reqMask, input logic [31:0] data,
                                 input int startDelay, input int busyCycles,
                                 input logic [3:0] busyReq, output int winnerOut);
        int         w;
        logic [7:0] expByte;
        w       = pickWinner(reqMask, modelLast);
        expByte = data[8*w +: 8];
        bus.req      = reqMask;
        bus.req_data = data;
        bus.TX_BUSSY = 1'b0;
        bus.TX_VALID = 1'b0;
        tick();
        checkOutput("grant_gnt",      32'(bus.gnt),       32'(oneHot(w)));
        checkOutput("grant_owner",    32'(bus.owner),     32'(w));
        checkOutput("grant_byte",     32'(bus.TX_BYTE),   32'(expByte));
        checkOutput("grant_txen",     32'(bus.tx_enable), 32'd1);
        checkOutput("grant_done",     32'(bus.done),      32'd0);
        checkOutput("grant_tmo",      32'(bus.timeout_err), 32'd0);
        modelLast    = w;
        bus.req      = busyReq;
        bus.req_data = $urandom();
        for (int i = 0; i < startDelay; i++) begin
            bus.TX_VALID = ($urandom_range(0, 1) == 1);
            tick();
            checkOutput("start_txen", 32'(bus.tx_enable), 32'd1);
            checkOutput("start_gnt",  32'(bus.gnt),       32'd0);
            checkOutput("start_done", 32'(bus.done),      32'd0);
            checkOutput("start_byte", 32'(bus.TX_BYTE),   32'(expByte));
        end
        bus.TX_VALID = 1'b0;
        bus.TX_BUSSY = 1'b1;
        tick();
        for (int i = 0; i < busyCycles; i++) begin
            checkOutput("send_txen", 32'(bus.tx_enable), 32'd0);
            checkOutput("send_busy", 32'(bus.arb_busy),  32'd1);
            checkOutput("send_gnt",  32'(bus.gnt),       32'd0);
            checkOutput("send_done", 32'(bus.done),      32'd0);
            checkOutput("send_byte", 32'(bus.TX_BYTE),   32'(expByte));
            tick();
        end
        bus.TX_BUSSY = 1'b0;
        bus.TX_VALID = 1'b1;
        tick();
        bus.TX_VALID = 1'b0;
        checkOutput("done_done",  32'(bus.done),        32'(oneHot(w)));
        checkOutput("done_busy",  32'(bus.arb_busy),    32'd0);
        checkOutput("done_gnt",   32'(bus.gnt),         32'd0);
        checkOutput("done_txen",  32'(bus.tx_enable),   32'd0);
        checkOutput("done_tmo",   32'(bus.timeout_err), 32'd0);
        winnerOut = w;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gnt"},   32'(bus.gnt),         32'd0);
        checkOutput({tag, "_done"},  32'(bus.done),        32'd0);
        checkOutput({tag, "_txen"},  32'(bus.tx_enable),   32'd0);
        checkOutput({tag, "_byte"},  32'(bus.TX_BYTE),     32'h00);
        checkOutput({tag, "_owner"}, 32'(bus.owner),       32'd0);
        checkOutput({tag, "_busy"},  32'(bus.arb_busy),    32'd0);
        checkOutput({tag, "_tmo"},   32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        int w;
        int order [5];
        logic [3:0] mask;
        checks       = 0;
        errors       = 0;
        modelLast    = 3;
        rst          = 1'b1;
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        bus.TX_BUSSY = 1'b0;
        bus.TX_VALID = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checkResetState("reset");

        // All four requesting, held: strict rotation starting at 0.
        order = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1111, $urandom(), 1, 3, 4'b1111, w);
            checkOutput("rr_order", 32'(w), 32'(order[t]));
        end

        // Single requester 2 with a known byte.
        applyStimulus(4'b0100, 32'h12A5_3456, 2, 2, 4'b0000, w);
        checkOutput("single_winner", 32'(w), 32'd2);

        // Requester 1 raised while 3 is sending: no queuing, granted after done.
        applyStimulus(4'b1000, $urandom(), 1, 3, 4'b0010, w);
        checkOutput("late_owner3", 32'(w), 32'd3);
        applyStimulus(4'b0010, $urandom(), 0, 1, 4'b0000, w);
        checkOutput("late_winner1", 32'(w), 32'd1);

        // Stray transmitter strobes in IDLE are ignored.
        bus.req      = 4'b0000;
        bus.TX_VALID = 1'b1;
        bus.TX_BUSSY = 1'b1;
        tick();
        tick();
        bus.TX_VALID = 1'b0;
        bus.TX_BUSSY = 1'b0;
        checkOutput("idle_stray_busy", 32'(bus.arb_busy), 32'd0);
        checkOutput("idle_stray_done", 32'(bus.done),     32'd0);
        checkOutput("idle_stray_gnt",  32'(bus.gnt),      32'd0);
        checkOutput("idle_stray_txen", 32'(bus.tx_enable), 32'd0);

        // Reset in the middle of SEND: byte abandoned, no done.
        bus.req      = 4'b0100;
        bus.req_data = $urandom();
        tick();
        checkOutput("mid_gnt", 32'(bus.gnt), 32'b0100);
        bus.req      = 4'b0000;
        bus.TX_BUSSY = 1'b1;
        tick();
        checkOutput("mid_send_txen", 32'(bus.tx_enable), 32'd0);
        rst          = 1'b1;
        bus.TX_VALID = 1'b1;
        tick();
        rst          = 1'b0;
        bus.TX_VALID = 1'b0;
        bus.TX_BUSSY = 1'b0;
        checkResetState("midrst");
        modelLast = 3;
        applyStimulus(4'b0001, $urandom(), 1, 2, 4'b0000, w);
        checkOutput("post_reset_winner", 32'(w), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never goes busy: abort after 16 START cycles.
        begin
            int n;
            bus.req      = 4'b0010;
            bus.req_data = $urandom();
            tick();
            checkOutput("tmo_gnt", 32'(bus.gnt), 32'b0010);
            modelLast = 1;
            bus.req   = 4'b0000;
            n = 0;
            for (int c = 0; c < 64 && bus.tx_enable; c++) begin
                n++;
                tick();
            end
            checkOutput("tmo_start_cycles", 32'(n),              32'd16);
            checkOutput("tmo_pulse",        32'(bus.timeout_err), 32'd1);
            checkOutput("tmo_no_done",      32'(bus.done),        32'd0);
            checkOutput("tmo_idle",         32'(bus.arb_busy),    32'd0);
            tick();
            checkOutput("tmo_pulse_end",    32'(bus.timeout_err), 32'd0);
            applyStimulus(4'b1111, $urandom(), 1, 1, 4'b0000, w);
            checkOutput("tmo_next_winner", 32'(w), 32'd2);
        end
`endif

        // Randomized traffic with idle gaps and noisy req while busy.
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            bus.req = 4'b0000;
            for (int g = 0; g < gap; g++) begin
                tick();
                checkOutput("gap_busy", 32'(bus.arb_busy), 32'd0);
                checkOutput("gap_gnt",  32'(bus.gnt),      32'd0);
            end
            mask = 4'($urandom_range(1, 15));
            applyStimulus(mask, $urandom(), $urandom_range(0, 4), $urandom_range(1, 5),
                          4'($urandom_range(0, 15)), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
